// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like request/response channel. The master modport drives the request side
// and the slave modport drives the response side.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave SRAM-like arbiter. Data (m1) has priority and inst (m0) has a starvation guard.
// An in-order owner FIFO sends each response back to the master that issued the request.
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                clk,
    input  logic                resetn,
    sram_like_arbiter_if.slave  m0,
    sram_like_arbiter_if.slave  m1,
    sram_like_arbiter_if.master s,
    output logic                arb_err
);
    localparam int PTR_W = (MAX_OUTSTANDING > 2) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           cnt;
    logic                       lock_vld;
    logic                       lock_own;
    logic [SC_W-1:0]            starve_cnt;

    logic gnt_vld;
    logic gnt_own;
    logic room;
    logic s_req_int;
    logic accept;
    logic pop;
    logic head;
    logic lock_req;

    assign lock_req = lock_own ? m1.req : m0.req;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_own = 1'b0;
        if (lock_vld && lock_req) begin
            gnt_vld = 1'b1;
            gnt_own = lock_own;
        end else if (m1.req && !(m0.req && (starve_cnt == SC_W'(STARVE_LIMIT)))) begin
            gnt_vld = 1'b1;
            gnt_own = 1'b1;
        end else if (m0.req) begin
            gnt_vld = 1'b1;
            gnt_own = 1'b0;
        end
    end

    assign pop  = s.data_ok && (cnt != '0);
    assign head = owner_q[rd_ptr];

    // A completion in this cycle frees a slot, so a full FIFO can still accept.
    assign room      = (cnt < CNT_W'(MAX_OUTSTANDING)) || pop;
    assign s_req_int = resetn && gnt_vld && room;
    assign accept    = s_req_int && s.addr_ok;

    assign s.req   = s_req_int;
    assign s.wr    = gnt_own ? m1.wr    : m0.wr;
    assign s.size  = gnt_own ? m1.size  : m0.size;
    assign s.wstrb = gnt_own ? m1.wstrb : m0.wstrb;
    assign s.addr  = gnt_own ? m1.addr  : m0.addr;
    assign s.wdata = gnt_own ? m1.wdata : m0.wdata;

    assign m0.addr_ok = accept && !gnt_own;
    assign m1.addr_ok = accept &&  gnt_own;
    assign m0.data_ok = resetn && pop && !head;
    assign m1.data_ok = resetn && pop &&  head;
    assign m0.rdata   = s.rdata;
    assign m1.rdata   = s.rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            lock_vld   <= 1'b0;
            lock_own   <= 1'b0;
            starve_cnt <= '0;
            arb_err    <= 1'b0;
        end else begin
            if (accept) begin
                owner_q[wr_ptr] <= gnt_own;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase

            // Once presented, a request stays on the bus until the slave takes it.
            if (accept) begin
                lock_vld <= 1'b0;
            end else if (s_req_int) begin
                lock_vld <= 1'b1;
                lock_own <= gnt_own;
            end else if (lock_vld && !lock_req) begin
                lock_vld <= 1'b0;
            end

            if (!m0.req || (accept && !gnt_own)) begin
                starve_cnt <= '0;
            end else if (accept && gnt_own && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end

            if (s.data_ok && (cnt == '0)) begin
                arb_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: an owner scoreboard is filled on expected accepts
// and drained on slave responses, with combinational outputs checked mid-cycle.
module tb_sram_like_arbiter;
    logic clk;
    logic resetn;
    logic arb_err;
    int   tests;
    int   fails;
    int   sb[$];

    sram_like_arbiter_if m0_if ();
    sram_like_arbiter_if m1_if ();
    sram_like_arbiter_if s_if ();

    sram_like_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .m0      (m0_if.slave),
        .m1      (m1_if.slave),
        .s       (s_if.master),
        .arb_err (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // exp_acc: -1 no accept, 0 m0 accepted, 1 m1 accepted in this cycle.
    task automatic cyc(input int exp_acc);
        int o;
        #1;
        chk("m0_addr_ok", {31'd0, m0_if.addr_ok}, {31'd0, exp_acc == 0});
        chk("m1_addr_ok", {31'd0, m1_if.addr_ok}, {31'd0, exp_acc == 1});
        if (s_if.data_ok && sb.size() > 0) begin
            o = sb.pop_front();
            chk("m0_data_ok", {31'd0, m0_if.data_ok}, {31'd0, o == 0});
            chk("m1_data_ok", {31'd0, m1_if.data_ok}, {31'd0, o == 1});
            chk("rdata", (o == 1) ? m1_if.rdata : m0_if.rdata, s_if.rdata);
        end else begin
            chk("idle_m0_data_ok", {31'd0, m0_if.data_ok}, 32'd0);
            chk("idle_m1_data_ok", {31'd0, m1_if.data_ok}, 32'd0);
        end
        if (exp_acc >= 0) sb.push_back(exp_acc);
        @(posedge clk);
        #2;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        resetn = 1'b0;
        m0_if.req = 0; m0_if.wr = 0; m0_if.size = 2'd2; m0_if.wstrb = 4'hf;
        m0_if.addr = 32'h1000; m0_if.wdata = 32'h0;
        m1_if.req = 1; m1_if.wr = 0; m1_if.size = 2'd2; m1_if.wstrb = 4'hf;
        m1_if.addr = 32'h2000; m1_if.wdata = 32'h5555_aaaa;
        s_if.addr_ok = 1; s_if.data_ok = 0; s_if.rdata = 32'h0;

        // Reset holds the slave request off even with m1 requesting.
        #1;
        chk("rst_s_req", {31'd0, s_if.req}, 32'd0);
        cyc(-1);
        cyc(-1);
        chk("rst_arb_err", {31'd0, arb_err}, 32'd0);
        resetn = 1'b1;
        m1_if.req = 0;
        s_if.addr_ok = 0;
        cyc(-1);

        // Single m1 read, response two cycles after accept.
        m1_if.req = 1; m1_if.addr = 32'h100; s_if.addr_ok = 1;
        #1;
        chk("t1_s_req", {31'd0, s_if.req}, 32'd1);
        chk("t1_s_addr", s_if.addr, 32'h100);
        chk("t1_s_wdata", s_if.wdata, 32'h5555_aaaa);
        cyc(1);
        m1_if.req = 0; s_if.addr_ok = 0;
        cyc(-1);
        s_if.data_ok = 1; s_if.rdata = 32'hDEADBEEF;
        cyc(-1);
        s_if.data_ok = 0;

        // Both requesting continuously: four data grants then one inst grant.
        m0_if.req = 1; m0_if.addr = 32'h1000;
        m1_if.req = 1; m1_if.addr = 32'h2000;
        s_if.addr_ok = 1;
        for (int i = 0; i < 10; i++) begin
            s_if.data_ok = (i > 0);
            s_if.rdata = 32'hA000 + i;
            #1;
            chk("t2_s_addr", s_if.addr, (i % 5 == 4) ? 32'h1000 : 32'h2000);
            cyc((i % 5 == 4) ? 0 : 1);
        end
        m0_if.req = 0; m1_if.req = 0; s_if.addr_ok = 0;
        s_if.data_ok = 1; s_if.rdata = 32'hB000;
        cyc(-1);
        s_if.data_ok = 0;

        // A stalled m0 request keeps the bus until accepted.
        m0_if.req = 1; m0_if.addr = 32'h3000;
        #1; chk("t3_addr_c1", s_if.addr, 32'h3000);
        cyc(-1);
        m1_if.req = 1; m1_if.addr = 32'h4000;
        #1; chk("t3_addr_c2", s_if.addr, 32'h3000);
        cyc(-1);
        #1; chk("t3_addr_c3", s_if.addr, 32'h3000);
        cyc(-1);
        s_if.addr_ok = 1;
        #1; chk("t3_addr_acc", s_if.addr, 32'h3000);
        cyc(0);
        m0_if.req = 0;
        #1; chk("t3_addr_m1", s_if.addr, 32'h4000);
        cyc(1);
        m1_if.req = 0; s_if.addr_ok = 0;
        s_if.data_ok = 1; s_if.rdata = 32'hC000;
        cyc(-1);
        s_if.rdata = 32'hC001;
        cyc(-1);
        s_if.data_ok = 0;

        // Mixed owners back to back; responses follow accept order.
        s_if.addr_ok = 1;
        m0_if.req = 1; m1_if.req = 0; cyc(0);
        m0_if.req = 0; m1_if.req = 1; cyc(1);
        m0_if.req = 1; m1_if.req = 0; cyc(0);
        m0_if.req = 0; s_if.addr_ok = 0;
        s_if.data_ok = 1;
        s_if.rdata = 32'h1111_0000; cyc(-1);
        s_if.rdata = 32'h2222_0001; cyc(-1);
        s_if.rdata = 32'h3333_0002; cyc(-1);
        s_if.data_ok = 0;

        // Fill to the outstanding limit, then a completion reopens the port that cycle.
        m1_if.req = 1; s_if.addr_ok = 1;
        for (int i = 0; i < 4; i++) cyc(1);
        #1; chk("t5_full_s_req", {31'd0, s_if.req}, 32'd0);
        cyc(-1);
        s_if.data_ok = 1; s_if.rdata = 32'h5000;
        #1; chk("t5_reopen_s_req", {31'd0, s_if.req}, 32'd1);
        cyc(1);
        m1_if.req = 0; s_if.addr_ok = 0;
        for (int i = 0; i < 4; i++) begin
            s_if.rdata = 32'h5100 + i;
            cyc(-1);
        end

        // Nothing outstanding now: a stray response flags arb_err until reset.
        chk("t6_err_before", {31'd0, arb_err}, 32'd0);
        s_if.rdata = 32'h6000;
        cyc(-1);
        s_if.data_ok = 0;
        chk("t6_err_set", {31'd0, arb_err}, 32'd1);
        cyc(-1);
        chk("t6_err_held", {31'd0, arb_err}, 32'd1);
        resetn = 1'b0; m1_if.req = 1; s_if.addr_ok = 1;
        #1; chk("t6_rst_s_req", {31'd0, s_if.req}, 32'd0);
        cyc(-1);
        resetn = 1'b1; m1_if.req = 0; s_if.addr_ok = 0;
        chk("t6_err_cleared", {31'd0, arb_err}, 32'd0);
        s_if.data_ok = 1;
        cyc(-1);
        s_if.data_ok = 0;
        chk("t6_cnt_zero_err", {31'd0, arb_err}, 32'd1);
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
